// File: rtl/regfile_port_scheduler_pkg.sv
// Shared definitions for the register-file port scheduler: geometry of the
// backed register window, the sequencer state encoding and the window check.
package regfile_port_scheduler_pkg;

   localparam int unsigned DATA_W           = 32;
   localparam int unsigned ADDR_W           = 5;
   localparam int unsigned RF_BASE          = 8;
   localparam int unsigned RF_DEPTH         = 16;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   localparam logic [ADDR_W-1:0] RF_BASE_ADDR = ADDR_W'(RF_BASE);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ_A,
      ST_READ_B,
      ST_RESP,
      ST_WRITE
   } state_e;

   // True when addr falls inside RF_BASE .. RF_BASE+RF_DEPTH-1; address 0 ($zero) is never inside.
   function automatic logic in_window(input logic [ADDR_W-1:0] addr);
      int unsigned a;
      a = 32'(addr);
      return (a >= RF_BASE) && (a < RF_BASE + RF_DEPTH);
   endfunction

endpackage

// File: rtl/regfile_port_scheduler_if.sv
// Requester-side bus of the scheduler: operand-fetch request/response and
// writeback request. The master modport is decode/writeback, the slave is the scheduler.
interface regfile_port_scheduler_if;
   import regfile_port_scheduler_pkg::*;

   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              rd_resp_valid;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_resp_err;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_err;

   modport master (
      output rd_req_valid, rd_addr_a, rd_addr_b, wr_valid, wr_addr, wr_data,
      input  rd_req_ready, rd_resp_valid, rd_data_a, rd_data_b, rd_resp_err,
             wr_ready, wr_err
   );

   modport slave (
      input  rd_req_valid, rd_addr_a, rd_addr_b, wr_valid, wr_addr, wr_data,
      output rd_req_ready, rd_resp_valid, rd_data_a, rd_data_b, rd_resp_err,
             wr_ready, wr_err
   );

endinterface

// File: rtl/regfile_arbiter.sv
// Grant logic for the shared register-file port. Writes win by default, but a
// waiting read is forced through after STARVE_LIMIT consecutive write grants.
module regfile_arbiter
   import regfile_port_scheduler_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic idle_i,
   input  logic rd_valid_i,
   input  logic wr_valid_i,
   output logic rd_grant_o,
   output logic wr_grant_o
);

   localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;

   // Grants are only issued while the sequencer is idle; the starvation count tracks writes that bypassed a waiting read.
   always_comb begin
      rd_grant_o   = 1'b0;
      wr_grant_o   = 1'b0;
      starve_cnt_d = starve_cnt_q;
      if (idle_i) begin
         if (wr_valid_i && (!rd_valid_i || (starve_cnt_q < LIMIT))) begin
            wr_grant_o = 1'b1;
            if (rd_valid_i) begin
               if (starve_cnt_q != LIMIT) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
            end else begin
               starve_cnt_d = '0;
            end
         end else if (rd_valid_i) begin
            rd_grant_o   = 1'b1;
            starve_cnt_d = '0;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/regfile_port_scheduler.sv
// Serialises operand-fetch read pairs and writeback writes onto the single
// register-file port, one port operation per cycle, with window checking.
module regfile_port_scheduler
   import regfile_port_scheduler_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_port_scheduler_if.slave bus,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_addr,
   output logic [DATA_W-1:0]    rf_wdata,
   input  logic [DATA_W-1:0]    rf_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] cap_a_q, cap_a_d;
   logic [DATA_W-1:0] data_a_q, data_a_d;
   logic [DATA_W-1:0] data_b_q, data_b_d;

   logic idle;
   logic rd_grant;
   logic wr_grant;

   // Reset masks the grants so nothing is accepted on a reset edge.
   assign idle = (state_q == ST_IDLE) && !rst;

   regfile_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arbiter (
      .clk        (clk),
      .rst        (rst),
      .idle_i     (idle),
      .rd_valid_i (bus.rd_req_valid),
      .wr_valid_i (bus.wr_valid),
      .rd_grant_o (rd_grant),
      .wr_grant_o (wr_grant)
   );

   assign bus.rd_req_ready = rd_grant;
   assign bus.wr_ready     = wr_grant;
   assign bus.rd_data_a    = data_a_q;
   assign bus.rd_data_b    = data_b_q;

   // Sequencer state and datapath latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cap_a_q   <= '0;
         data_a_q  <= '0;
         data_b_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         cap_a_q   <= cap_a_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
      end
   end

   // Next state and latch updates; operand A is parked in cap_a so the visible
   // response registers only change on the edge into RESP.
   always_comb begin
      state_d   = state_q;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cap_a_d   = cap_a_q;
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_grant) begin
               state_d   = ST_WRITE;
               wr_addr_d = bus.wr_addr;
               wr_data_d = bus.wr_data;
            end else if (rd_grant) begin
               state_d  = ST_READ_A;
               addr_a_d = bus.rd_addr_a;
               addr_b_d = bus.rd_addr_b;
            end
         end
         ST_READ_A: begin
            state_d = ST_READ_B;
            cap_a_d = in_window(addr_a_q) ? rf_rdata : '0;
         end
         ST_READ_B: begin
            state_d  = ST_RESP;
            data_a_d = cap_a_q;
            data_b_d = in_window(addr_b_q) ? rf_rdata : '0;
         end
         ST_RESP:  state_d = ST_IDLE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Port drive and status pulses decoded from the current state.
   always_comb begin
      rf_we             = 1'b0;
      rf_addr           = RF_BASE_ADDR;
      rf_wdata          = '0;
      bus.rd_resp_valid = 1'b0;
      bus.rd_resp_err   = 1'b0;
      bus.wr_err        = 1'b0;
      case (state_q)
         ST_READ_A: begin
            if (in_window(addr_a_q)) rf_addr = addr_a_q;
         end
         ST_READ_B: begin
            if (in_window(addr_b_q)) rf_addr = addr_b_q;
         end
         ST_RESP: begin
            bus.rd_resp_valid = 1'b1;
            bus.rd_resp_err   = !in_window(addr_a_q) || !in_window(addr_b_q);
         end
         ST_WRITE: begin
            if (in_window(wr_addr_q)) begin
               rf_we    = 1'b1;
               rf_addr  = wr_addr_q;
               rf_wdata = wr_data_q;
            end else begin
               bus.wr_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Self-checking bench for regfile_port_scheduler with a behavioural register file.
`timescale 1ns/1ps
module tb_regfile_port_scheduler;
   import regfile_port_scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_port_scheduler_if bus();
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata;

   regfile_port_scheduler #(.STARVE_LIMIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .rf_we    (rf_we),
      .rf_addr  (rf_addr),
      .rf_wdata (rf_wdata),
      .rf_rdata (rf_rdata)
   );

   // Behavioural register file behind the port.
   logic [31:0] rf_mem [32];
   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

   // Architectural view expected by the requesters.
   logic [31:0] exp_rf [32];
   logic [31:0] last_a, last_b;
   int errors = 0;
   int checks = 0;

   function automatic bit win(input logic [4:0] a);
      return (a >= 5'd8) && (a <= 5'd23);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      return win(a) ? exp_rf[a] : 32'h0;
   endfunction

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      #1; n = 0;
      while (bus.wr_ready !== 1'b1 && n < 16) begin @(negedge clk); #1; n++; end
      checks++;
      if (bus.wr_ready !== 1'b1) begin
         errors++; $display("FAIL wr_accept: wr_ready=%b want 1", bus.wr_ready);
         bus.wr_valid = 1'b0; return;
      end
      @(negedge clk);
      bus.wr_valid = 1'b0; bus.wr_addr = 5'($urandom); bus.wr_data = $urandom;
      #1;
      checks++;
      if (rf_we !== win(a) || bus.wr_err !== !win(a)) begin
         errors++; $display("FAIL wr_cycle addr=%0d: rf_we=%b wr_err=%b want %b/%b", a, rf_we, bus.wr_err, win(a), !win(a));
      end
      if (win(a)) begin
         checks++;
         if (rf_addr !== a || rf_wdata !== d) begin
            errors++; $display("FAIL wr_port: rf_addr=%0d rf_wdata=%h want %0d/%h", rf_addr, rf_wdata, a, d);
         end
         exp_rf[a] = d;
      end
      @(negedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || bus.wr_err !== 1'b0 || rf_addr !== 5'd8 || rf_wdata !== 32'h0) begin
         errors++; $display("FAIL wr_pulse_end: rf_we=%b wr_err=%b rf_addr=%0d rf_wdata=%h want 0/0/8/0", rf_we, bus.wr_err, rf_addr, rf_wdata);
      end
   endtask

   task automatic do_read(input logic [4:0] a, input logic [4:0] b);
      int n;
      logic [31:0] ea, eb;
      logic ee;
      @(negedge clk);
      bus.rd_req_valid = 1'b1; bus.rd_addr_a = a; bus.rd_addr_b = b;
      #1; n = 0;
      while (bus.rd_req_ready !== 1'b1 && n < 16) begin @(negedge clk); #1; n++; end
      checks++;
      if (bus.rd_req_ready !== 1'b1) begin
         errors++; $display("FAIL rd_accept: rd_req_ready=%b want 1", bus.rd_req_ready);
         bus.rd_req_valid = 1'b0; return;
      end
      ea = exp_read(a); eb = exp_read(b); ee = !win(a) || !win(b);
      @(negedge clk);
      bus.rd_req_valid = 1'b0; bus.rd_addr_a = 5'($urandom); bus.rd_addr_b = 5'($urandom);
      #1;
      checks++;
      if (rf_we !== 1'b0 || rf_addr !== (win(a) ? a : 5'd8) || bus.rd_resp_valid !== 1'b0 || bus.rd_data_a !== last_a) begin
         errors++; $display("FAIL read_a: we=%b addr=%0d rv=%b da=%h want 0/%0d/0/%h", rf_we, rf_addr, bus.rd_resp_valid, bus.rd_data_a, win(a) ? a : 5'd8, last_a);
      end
      @(negedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || rf_addr !== (win(b) ? b : 5'd8) || bus.rd_resp_valid !== 1'b0 || bus.rd_data_b !== last_b) begin
         errors++; $display("FAIL read_b: we=%b addr=%0d rv=%b db=%h want 0/%0d/0/%h", rf_we, rf_addr, bus.rd_resp_valid, bus.rd_data_b, win(b) ? b : 5'd8, last_b);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_err !== ee) begin
         errors++; $display("FAIL resp (%0d,%0d): valid=%b err=%b want 1/%b", a, b, bus.rd_resp_valid, bus.rd_resp_err, ee);
      end
      checks++;
      if (bus.rd_data_a !== ea || bus.rd_data_b !== eb) begin
         errors++; $display("FAIL resp_data (%0d,%0d): a=%h b=%h want %h/%h", a, b, bus.rd_data_a, bus.rd_data_b, ea, eb);
      end
      last_a = ea; last_b = eb;
      @(negedge clk); #1;
      checks++;
      if (bus.rd_resp_valid !== 1'b0 || bus.rd_resp_err !== 1'b0 || bus.rd_data_a !== last_a || bus.rd_data_b !== last_b) begin
         errors++; $display("FAIL resp_end: valid=%b err=%b a=%h b=%h want 0/0/%h/%h", bus.rd_resp_valid, bus.rd_resp_err, bus.rd_data_a, bus.rd_data_b, last_a, last_b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rd_req_valid = 1'b0; bus.wr_valid = 1'b0;
      bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.wr_addr = '0; bus.wr_data = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (rf_we !== 1'b0 || rf_addr !== 5'd8 || rf_wdata !== 32'h0 || bus.rd_resp_valid !== 1'b0 || bus.rd_resp_err !== 1'b0 ||
          bus.wr_err !== 1'b0 || bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0 || bus.rd_req_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
         errors++; $display("FAIL reset_state: we=%b addr=%0d wd=%h rv=%b re=%b we_err=%b a=%h b=%h rr=%b wr=%b want 0/8/0/0/0/0/0/0/0/0",
                            rf_we, rf_addr, rf_wdata, bus.rd_resp_valid, bus.rd_resp_err, bus.wr_err, bus.rd_data_a, bus.rd_data_b, bus.rd_req_ready, bus.wr_ready);
      end
      last_a = 32'h0; last_b = 32'h0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      do_write(5'd9, 32'hDEADBEEF);
      do_read(5'd9, 5'd9);
   endtask

   task automatic test_window();
      do_write(5'd8, 32'h11);
      do_write(5'd23, 32'h22);
      do_read(5'd8, 5'd23);
      do_read(5'd24, 5'd7);
   endtask

   task automatic test_zero_reg();
      do_write(5'd0, 32'h5);
      do_read(5'd0, 5'd0);
      do_read(5'd0, 5'd9);
   endtask

   task automatic test_starvation();
      bit exp_w [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      logic [31:0] qa [$], qb [$];
      logic qe [$];
      logic [31:0] pa, pb;
      logic pe;
      int g = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         bus.wr_valid = (g < 10); bus.rd_req_valid = (g < 10);
         bus.wr_addr = 5'($urandom); bus.wr_data = $urandom;
         bus.rd_addr_a = 5'($urandom_range(8, 23)); bus.rd_addr_b = 5'($urandom);
         #1;
         if (bus.rd_resp_valid === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
               errors++; $display("FAIL starve_resp: unexpected response");
            end else begin
               pa = qa.pop_front(); pb = qb.pop_front(); pe = qe.pop_front();
               if (bus.rd_data_a !== pa || bus.rd_data_b !== pb || bus.rd_resp_err !== pe) begin
                  errors++; $display("FAIL starve_resp: a=%h b=%h err=%b want %h/%h/%b", bus.rd_data_a, bus.rd_data_b, bus.rd_resp_err, pa, pb, pe);
               end
               last_a = pa; last_b = pb;
            end
         end
         if (bus.wr_ready === 1'b1 || bus.rd_req_ready === 1'b1) begin
            checks++;
            if (bus.wr_ready === 1'b1 && bus.rd_req_ready === 1'b1) begin
               errors++; $display("FAIL grant_onehot: wr_ready=1 rd_req_ready=1 want one");
            end else if (g >= 10) begin
               errors++; $display("FAIL grant_extra: grant %0d beyond sequence", g);
            end else if (bus.wr_ready !== exp_w[g]) begin
               errors++; $display("FAIL grant_order #%0d: got %s want %s", g, bus.wr_ready ? "W" : "R", exp_w[g] ? "W" : "R");
            end
            if (bus.wr_ready === 1'b1) begin
               if (win(bus.wr_addr)) exp_rf[bus.wr_addr] = bus.wr_data;
            end else begin
               qa.push_back(exp_read(bus.rd_addr_a));
               qb.push_back(exp_read(bus.rd_addr_b));
               qe.push_back(!win(bus.rd_addr_a) || !win(bus.rd_addr_b));
            end
            g++;
         end
         @(negedge clk);
      end
      checks++;
      if (g != 10 || qa.size() != 0) begin
         errors++; $display("FAIL starve_done: grants=%0d pending=%0d want 10/0", g, qa.size());
      end
   endtask

   task automatic test_hazard();
      int n, resp_cyc, ready_cyc, we_cyc;
      logic [31:0] old_v, new_v;
      old_v = $urandom; new_v = ~old_v;
      do_write(5'd10, old_v);
      @(negedge clk);
      bus.rd_req_valid = 1'b1; bus.rd_addr_a = 5'd10; bus.rd_addr_b = 5'd10;
      #1; n = 0;
      while (bus.rd_req_ready !== 1'b1 && n < 16) begin @(negedge clk); #1; n++; end
      checks++;
      if (bus.rd_req_ready !== 1'b1) begin
         errors++; $display("FAIL hazard_accept: rd_req_ready=%b want 1", bus.rd_req_ready);
      end
      @(negedge clk);
      bus.rd_req_valid = 1'b0;
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = new_v;
      resp_cyc = 0; ready_cyc = 0; we_cyc = 0;
      for (int c = 1; c <= 7; c++) begin
         #1;
         if (bus.rd_resp_valid === 1'b1) begin
            resp_cyc = c;
            checks++;
            if (bus.rd_data_a !== old_v || bus.rd_data_b !== old_v) begin
               errors++; $display("FAIL hazard_old: a=%h b=%h want %h", bus.rd_data_a, bus.rd_data_b, old_v);
            end
            last_a = old_v; last_b = old_v;
         end
         if (bus.wr_ready === 1'b1 && ready_cyc == 0) ready_cyc = c;
         if (rf_we === 1'b1) begin
            we_cyc = c;
            checks++;
            if (rf_addr !== 5'd10 || rf_wdata !== new_v) begin
               errors++; $display("FAIL hazard_wport: addr=%0d data=%h want 10/%h", rf_addr, rf_wdata, new_v);
            end
         end
         @(negedge clk);
         if (ready_cyc != 0) bus.wr_valid = 1'b0;
      end
      exp_rf[10] = new_v;
      checks++;
      if (resp_cyc != 3 || ready_cyc != 4 || we_cyc != 5) begin
         errors++; $display("FAIL hazard_timing: resp=%0d wr_ready=%0d we=%0d want 3/4/5", resp_cyc, ready_cyc, we_cyc);
      end
      do_read(5'd10, 5'd10);
   endtask

   task automatic test_reset_mid();
      int n;
      @(negedge clk);
      bus.rd_req_valid = 1'b1; bus.rd_addr_a = 5'd9; bus.rd_addr_b = 5'd23;
      #1; n = 0;
      while (bus.rd_req_ready !== 1'b1 && n < 16) begin @(negedge clk); #1; n++; end
      checks++;
      if (bus.rd_req_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_accept: rd_req_ready=%b want 1", bus.rd_req_ready);
      end
      @(negedge clk); bus.rd_req_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || rf_addr !== 5'd8 || rf_wdata !== 32'h0 || bus.rd_resp_valid !== 1'b0 || bus.rd_resp_err !== 1'b0 ||
          bus.wr_err !== 1'b0 || bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0 || bus.rd_req_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_state: we=%b addr=%0d rv=%b a=%h b=%h want 0/8/0/0/0", rf_we, rf_addr, bus.rd_resp_valid, bus.rd_data_a, bus.rd_data_b);
      end
      last_a = 32'h0; last_b = 32'h0;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         checks++;
         if (bus.rd_resp_valid !== 1'b0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet: rv=%b we=%b want 0/0", bus.rd_resp_valid, rf_we);
         end
      end
      do_read(5'd9, 5'd23);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) do_write(5'($urandom), $urandom);
         else do_read(5'($urandom), 5'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = $urandom;
         exp_rf[i] = rf_mem[i];
      end
      test_reset();
      test_basic();
      test_window();
      test_zero_reg();
      test_starvation();
      test_hazard();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
